mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access stage directly downstream of EX in the MIPS pipeline. Consumes EX results (op, regcData/Write/Addr, memAddr, memData).
//  Performs lw/lb/lbu/sw/sb against the data RAM with a req/ack handshake; all other ops pass through.
//  Drives the writeback port of the register file. Stalls EX via in_ready while an access is outstanding.
// PARAMETERS
//  ACK_TIMEOUT  16  max cycles dm_req may wait for dm_ack before bus error (>=2)
//  CNT_W         5  width of timeout counter; must hold ACK_TIMEOUT
// PORTS
//  clk          in   1   single clock, all state on posedge
//  rst          in   1   synchronous, active-low reset
//  op_i         in   6   opcode from EX (define.v op codes)
//  regcData_i   in  32   EX result
//  regcWrite_i  in   1   EX writeback enable
//  regcAddr_i   in   5   EX destination register
//  memAddr_i    in  32   effective address from EX
//  memData_i    in  32   store data from EX
//  in_valid     in   1   EX presents an instruction this cycle
//  in_ready     out  1   stage can accept; low = stall EX
//  dm_req       out  1   data-RAM request
//  dm_we        out  1   1 = write
//  dm_be        out  4   byte enables, bit0 = addr[1:0]==0 (little-endian)
//  dm_addr      out 32   word address {addr[31:2],2'b00}
//  dm_wdata     out 32   store data, byte replicated to all lanes for sb
//  dm_ack       in   1   RAM completes access this cycle
//  dm_rdata     in  32   read data, valid with dm_ack
//  regcData     out 32   writeback data
//  regcWrite    out  1   writeback enable
//  regcAddr     out  5   writeback register
//  wb_valid     out  1   writeback outputs valid this cycle (1-cycle pulse)
//  exc_align    out  1   misaligned lw/sw detected (1-cycle pulse)
//  exc_bus      out  1   ack timeout (1-cycle pulse)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; all outputs 0 except in_ready=1; counter=0. Outstanding request is dropped.
//  FSM states: IDLE, ACCESS.
//  IDLE, in_valid=0: wb_valid=0, regcWrite=0.
//  IDLE, in_valid=1, non-memory op: next cycle regcData/Write/Addr = inputs, wb_valid=1. Latency 1, throughput 1/cycle.
//  IDLE, in_valid=1, lw/sw with memAddr_i[1:0]!=0: no request; next cycle exc_align=1, wb_valid=1, regcWrite=0.
//  IDLE, in_valid=1, legal memory op: latch op, addr, data, dest; go ACCESS; in_ready=0 from the next cycle.
//   lb/lbu/sb are never misaligned.
//  ACCESS:
//   - dm_req=1, with dm_we/dm_be/dm_addr/dm_wdata held stable until ack.
//   - lw/sw: be=4'b1111. lb/lbu/sb: be=1<<addr[1:0].
//   - Counter increments each cycle without ack.
//   - dm_ack: dm_req drops the next cycle; return to IDLE; wb_valid=1 next cycle.
//     lw: regcData = dm_rdata. lb: sign-extend selected lane. lbu: zero-extend selected lane.
//     Loads regcWrite = latched regcWrite_i. Stores regcWrite=0.
//   - Counter reaching ACK_TIMEOUT with no ack: drop req; exc_bus=1, wb_valid=1, regcWrite=0; IDLE.
//   - Ack in the same cycle the counter hits the limit: ack wins, no exc_bus.
//  in_ready = (state==IDLE). The cycle that returns to IDLE may accept a new instruction (back-to-back).
//  dm_ack outside ACCESS: ignored.
//  regcAddr==0 with regcWrite=1 is forwarded unchanged; the register file ignores r0.
// STRUCTURE
//  Op codes (lw, sw, lb, lbu, sb) and RstEnable-style constants live in define.v; add new codes there only.
//  Sub-module load_align:
//   - combinational; inputs rdata, addr[1:0], op; output formatted 32-bit load value.
//   - Also reused by the WB bench as reference model.
//  FSM, counter and output registers stay in mem_stage.
// TESTING
//  1. add passthrough: in_valid, regcData_i=0x1234, regcAddr_i=5, regcWrite_i=1 -> next cycle wb_valid=1, regcData=0x1234, regcAddr=5.
//  2. lw 0x100, ack after 3 cycles, rdata=0xDEADBEEF -> in_ready low 4 cycles; dm_be=F; regcData=0xDEADBEEF, regcWrite=1.
//  3. lb addr 0x103, rdata=0x80000000 -> dm_be=4'b1000, regcData=0xFFFFFF80; lbu same -> 0x00000080.
//  4. sb addr 0x102, memData_i=0xAB -> dm_we=1, be=4'b0100, wdata=0xABABABAB, regcWrite=0.
//  5. lw addr 0x102 -> no dm_req; exc_align=1 one cycle; regcWrite=0.
//  6. Timeout and reset: sw with no ack -> exc_bus at cycle 16, req drops.
//     rst=0 mid-ACCESS -> next cycle dm_req=0, in_ready=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared opcodes, FSM state type and writeback record for the MEM pipeline stage.
// The opcode values mirror the MIPS primary opcodes used by the rest of the pipeline.
package mem_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        write;
        logic [4:0]  addr;
        logic        valid;
        logic        exc_align;
        logic        exc_bus;
    } wb_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {OP_LB, OP_LBU, OP_LW};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {OP_SB, OP_SW};
    endfunction

    function automatic logic is_word(input logic [5:0] op);
        return op inside {OP_LW, OP_SW};
    endfunction

    function automatic logic [3:0] byte_enable(input logic [5:0] op, input logic [1:0] lane);
        return is_word(op) ? 4'b1111 : (4'b0001 << lane);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-RAM request/acknowledge bus between the MEM stage (master) and the RAM (slave).
interface mem_stage_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, be, addr, wdata, input ack, rdata);
    modport slave  (input req, we, be, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load formatter: picks the addressed byte lane and extends it,
// or passes the whole word through for lw.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [5:0]  op,
    output logic [31:0] data
);

    logic [7:0] lane_byte;

    always_comb begin
        lane_byte = rdata[{addr, 3'b000} +: 8];
        case (op)
            OP_LB:   data = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  data = {24'h0, lane_byte};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: runs loads/stores over the data-RAM handshake with an ack
// timeout, passes other ops straight to writeback, and stalls EX while busy.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op_i,
    input  logic [31:0] regcData_i,
    input  logic        regcWrite_i,
    input  logic [4:0]  regcAddr_i,
    input  logic [31:0] memAddr_i,
    input  logic [31:0] memData_i,
    input  logic        in_valid,
    output logic        in_ready,
    mem_stage_if.master dm,
    output logic [31:0] regcData,
    output logic        regcWrite,
    output logic [4:0]  regcAddr,
    output logic        wb_valid,
    output logic        exc_align,
    output logic        exc_bus
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    wb_t              wb_q, wb_nxt;
    logic             accept;

    logic [5:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        wen_q;
    logic [4:0]  dest_q;
    logic [31:0] load_data;

    load_align u_load_align (
        .rdata (dm.rdata),
        .addr  (addr_q[1:0]),
        .op    (op_q),
        .data  (load_data)
    );

    always_comb begin
        // NOTE: every signal written here is given a default first, so no latch can be inferred.
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        wb_nxt    = '0;
        wb_nxt.data = wb_q.data;
        wb_nxt.addr = wb_q.addr;

        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (!(is_load(op_i) || is_store(op_i))) begin
                        wb_nxt.data  = regcData_i;
                        wb_nxt.write = regcWrite_i;
                        wb_nxt.addr  = regcAddr_i;
                        wb_nxt.valid = 1'b1;
                    end else if (is_word(op_i) && memAddr_i[1:0] != 2'b00) begin
                        wb_nxt.addr      = regcAddr_i;
                        wb_nxt.valid     = 1'b1;
                        wb_nxt.exc_align = 1'b1;
                    end else begin
                        accept    = 1'b1;
                        state_nxt = ST_ACCESS;
                        cnt_nxt   = '0;
                    end
                end
            end
            ST_ACCESS: begin
                // Ack is tested first so an ack on the final allowed cycle still completes.
                if (dm.ack) begin
                    state_nxt    = ST_IDLE;
                    wb_nxt.valid = 1'b1;
                    wb_nxt.addr  = dest_q;
                    if (is_load(op_q)) begin
                        wb_nxt.data  = load_data;
                        wb_nxt.write = wen_q;
                    end
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_nxt      = ST_IDLE;
                    wb_nxt.valid   = 1'b1;
                    wb_nxt.addr    = dest_q;
                    wb_nxt.exc_bus = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous and sampled here; state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wb_q    <= '0;
            op_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            wen_q   <= 1'b0;
            dest_q  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            wb_q  <= wb_nxt;
            if (accept) begin
                op_q    <= op_i;
                addr_q  <= memAddr_i;
                wdata_q <= (op_i == OP_SB) ? {4{memData_i[7:0]}} : memData_i;
                be_q    <= byte_enable(op_i, memAddr_i[1:0]);
                wen_q   <= regcWrite_i;
                dest_q  <= regcAddr_i;
            end
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign dm.req    = (state == ST_ACCESS);
    assign dm.we     = dm.req && is_store(op_q);
    assign dm.be     = dm.req ? be_q : 4'b0000;
    assign dm.addr   = dm.req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dm.wdata  = dm.req ? wdata_q : 32'h0;

    assign regcData  = wb_q.data;
    assign regcWrite = wb_q.write;
    assign regcAddr  = wb_q.addr;
    assign wb_valid  = wb_q.valid;
    assign exc_align = wb_q.exc_align;
    assign exc_bus   = wb_q.exc_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases, then random traffic
// compared against an arithmetic model of load/store formatting and timing.
module tb_mem_stage;
    import mem_stage_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  op_i = '0;
    logic [31:0] regcData_i = '0;
    logic        regcWrite_i = 1'b0;
    logic [4:0]  regcAddr_i = '0;
    logic [31:0] memAddr_i = '0;
    logic [31:0] memData_i = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] regcData;
    logic        regcWrite;
    logic [4:0]  regcAddr;
    logic        wb_valid;
    logic        exc_align;
    logic        exc_bus;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_if dm ();

    mem_stage #(.ACK_TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_i        (op_i),
        .regcData_i  (regcData_i),
        .regcWrite_i (regcWrite_i),
        .regcAddr_i  (regcAddr_i),
        .memAddr_i   (memAddr_i),
        .memData_i   (memData_i),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dm          (dm),
        .regcData    (regcData),
        .regcWrite   (regcWrite),
        .regcAddr    (regcAddr),
        .wb_valid    (wb_valid),
        .exc_align   (exc_align),
        .exc_bus     (exc_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_be(input logic [5:0] op, input logic [1:0] lane);
        logic [3:0] lanes [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        if (op == OP_LW || op == OP_SW) return 4'b1111;
        return lanes[lane];
    endfunction

    function automatic logic [31:0] exp_load(input logic [5:0] op, input logic [31:0] rdata,
                                             input logic [1:0] lane);
        logic [31:0] b;
        b = (rdata >> (8 * int'(lane))) & 32'hFF;
        if (op == OP_LW) return rdata;
        if (op == OP_LB && b >= 32'd128) return b - 32'd256;
        return b;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [5:0] op, input logic [31:0] mdata);
        if (op == OP_SB) return (mdata & 32'hFF) * 32'h01010101;
        return mdata;
    endfunction

    task automatic drive(input logic [5:0] op, input logic [31:0] data, input logic wen,
                         input logic [4:0] dest, input logic [31:0] maddr, input logic [31:0] mdata);
        op_i = op; regcData_i = data; regcWrite_i = wen; regcAddr_i = dest;
        memAddr_i = maddr; memData_i = mdata; in_valid = 1'b1;
    endtask

    task automatic passthru(input string tag, input logic [31:0] data, input logic wen,
                            input logic [4:0] dest);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        drive(6'h00, data, wen, dest, 32'h0, 32'h0);
        step();
        in_valid = 1'b0;
        check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        check({tag, "_data"}, regcData, data);
        check({tag, "_addr"}, 32'(regcAddr), 32'(dest));
        check({tag, "_wen"}, 32'(regcWrite), 32'(wen));
    endtask

    task automatic misaligned(input string tag, input logic [5:0] op, input logic [31:0] maddr);
        drive(op, 32'h0, 1'b1, 5'd9, maddr, 32'h5555_AAAA);
        step();
        in_valid = 1'b0;
        check({tag, "_noreq"}, 32'(dm.req), 32'd0);
        check({tag, "_exc"}, 32'(exc_align), 32'd1);
        check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        check({tag, "_wen"}, 32'(regcWrite), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        step();
        check({tag, "_pulse"}, 32'(exc_align), 32'd0);
    endtask

    task automatic mem_txn(input string tag, input logic [5:0] op, input logic [31:0] maddr,
                           input logic [31:0] mdata, input logic [31:0] rdata,
                           input logic [4:0] dest, input logic wen, input int delay);
        int   low;
        logic ld;
        low = 0;
        ld  = (op == OP_LW || op == OP_LB || op == OP_LBU);
        drive(op, 32'h0, wen, dest, maddr, mdata);
        step();
        in_valid = 1'b0;
        for (int i = 0; i <= delay; i++) begin
            if (!in_ready) low++;
            check({tag, "_req"}, 32'(dm.req), 32'd1);
            check({tag, "_be"}, 32'(dm.be), 32'(exp_be(op, maddr[1:0])));
            if (i == 0) begin
                check({tag, "_we"}, 32'(dm.we), 32'(!ld));
                check({tag, "_daddr"}, dm.addr, maddr & 32'hFFFF_FFFC);
                if (!ld) check({tag, "_wdata"}, dm.wdata, exp_wdata(op, mdata));
            end
            if (i == delay) begin
                dm.ack = 1'b1;
                dm.rdata = rdata;
            end
            step();
        end
        dm.ack = 1'b0;
        dm.rdata = $urandom;
        check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
        check({tag, "_wen"}, 32'(regcWrite), ld ? 32'(wen) : 32'd0);
        if (ld) begin
            check({tag, "_data"}, regcData, exp_load(op, rdata, maddr[1:0]));
            check({tag, "_dest"}, 32'(regcAddr), 32'(dest));
        end
        check({tag, "_bus"}, 32'(exc_bus), 32'd0);
        check({tag, "_reqdrop"}, 32'(dm.req), 32'd0);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_stall"}, 32'(low), 32'(delay + 1));
    endtask

    initial begin
        int hi;
        dm.ack = 1'b0;
        dm.rdata = '0;

        // Reset state
        step();
        step();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_req", 32'(dm.req), 32'd0);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        check("rst_wen", 32'(regcWrite), 32'd0);
        check("rst_data", regcData, 32'h0);
        check("rst_exc", 32'({exc_align, exc_bus}), 32'd0);
        rst = 1'b1;
        step();

        // Pass-through, back-to-back, and r0 forwarded unchanged
        passthru("add", 32'h1234, 1'b1, 5'd5);
        passthru("add_b2b", 32'hCAFE_0001, 1'b0, 5'd7);
        passthru("add_r0", 32'h0BAD_F00D, 1'b1, 5'd0);
        step();
        check("idle_wbv", 32'(wb_valid), 32'd0);
        check("idle_wen", 32'(regcWrite), 32'd0);

        // Directed memory ops
        mem_txn("lw", OP_LW, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 1'b1, 3);
        mem_txn("lb", OP_LB, 32'h103, 32'h0, 32'h80000000, 5'd4, 1'b1, 1);
        mem_txn("lbu", OP_LBU, 32'h103, 32'h0, 32'h80000000, 5'd4, 1'b1, 0);
        mem_txn("sb", OP_SB, 32'h102, 32'hAB, 32'h0, 5'd0, 1'b0, 2);
        misaligned("lw_mis", OP_LW, 32'h102);
        misaligned("sw_mis", OP_SW, 32'h101);

        // Ack on the last allowed cycle wins over the timeout
        mem_txn("ack_edge", OP_SW, 32'h200, 32'h1111_2222, 32'h0, 5'd0, 1'b0, TIMEOUT - 1);

        // Timeout with no ack
        drive(OP_SW, 32'h0, 1'b0, 5'd0, 32'h300, 32'h7777_8888);
        step();
        in_valid = 1'b0;
        hi = 0;
        while (dm.req && hi < 40) begin
            hi++;
            step();
        end
        check("to_cycles", 32'(hi), 32'(TIMEOUT));
        check("to_exc", 32'(exc_bus), 32'd1);
        check("to_wbv", 32'(wb_valid), 32'd1);
        check("to_wen", 32'(regcWrite), 32'd0);
        check("to_ready", 32'(in_ready), 32'd1);
        step();
        check("to_pulse", 32'(exc_bus), 32'd0);

        // Reset in the middle of an access, then a stray ack while idle
        drive(OP_LW, 32'h0, 1'b1, 5'd6, 32'h400, 32'h0);
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid_rst_req", 32'(dm.req), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_wbv", 32'(wb_valid), 32'd0);
        dm.ack = 1'b1;
        dm.rdata = 32'hFFFF_FFFF;
        step();
        dm.ack = 1'b0;
        check("stray_ack_wbv", 32'(wb_valid), 32'd0);
        check("stray_ack_req", 32'(dm.req), 32'd0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            logic [5:0]  ops [5] = '{OP_LW, OP_SW, OP_LB, OP_LBU, OP_SB};
            int          kind;
            logic [31:0] maddr;
            logic [5:0]  op;
            kind  = $urandom_range(0, 5);
            maddr = $urandom;
            if (kind == 5) begin
                passthru("rnd_alu", $urandom, 1'($urandom), 5'($urandom));
            end else begin
                op = ops[kind];
                if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0)
                    maddr[1:0] = 2'b00;
                if ((op == OP_LW || op == OP_SW) && maddr[1:0] != 2'b00)
                    misaligned("rnd_mis", op, maddr);
                else
                    mem_txn("rnd_mem", op, maddr, $urandom, $urandom, 5'($urandom),
                            1'($urandom), $urandom_range(0, 5));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
